// File: rtl/sp_core_pkg.sv
// Shared constants for the SP lane: ALU op codes, write-back source codes, widths and bench clock.
// MAD support is selected at build time with the SPCORE_MAD_EN macro (see sp_core.sv).
package sp_core_pkg;

    localparam int DATA_W     = 16;
    localparam int RA_W       = 4;
    localparam int CLK_PERIOD = 10;

    localparam logic [3:0] ALUC_CLEAR = 4'd0;
    localparam logic [3:0] ALUC_ADD   = 4'd1;
    localparam logic [3:0] ALUC_SUB   = 4'd2;
    localparam logic [3:0] ALUC_MUL   = 4'd3;
    localparam logic [3:0] ALUC_MAD   = 4'd4;
    localparam logic [3:0] ALUC_AND   = 4'd5;
    localparam logic [3:0] ALUC_OR    = 4'd6;
    localparam logic [3:0] ALUC_XOR   = 4'd7;
    localparam logic [3:0] ALUC_SLT   = 4'd8;
    localparam logic [3:0] ALUC_SEQ   = 4'd9;

    localparam logic [1:0] MUXD_FROM_ALU = 2'd0;
    localparam logic [1:0] MUXD_FROM_I   = 2'd1;
    localparam logic [1:0] MUXD_FROM_MEM = 2'd2;
    localparam logic [1:0] MUXD_FROM_REG = 2'd3;

endpackage

// File: rtl/sp_regfile.sv
// SP register file: asynchronous read ports for x/y/z indices and one synchronous write port.
// Storage is named "register" so it can be inspected hierarchically.
module sp_regfile
    import sp_core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [RA_W-1:0]   ra_x,
    input  logic [RA_W-1:0]   ra_y,
    input  logic [RA_W-1:0]   ra_z,
    output logic [DATA_W-1:0] rd_x,
    output logic [DATA_W-1:0] rd_y,
    output logic [DATA_W-1:0] rd_z
);

    logic [DATA_W-1:0] register [0:(2**RA_W)-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**RA_W; i++) begin
                register[i] <= '0;
            end
        end else if (we) begin
            register[wa] <= wd;
        end
    end

    // Reads see the pre-edge contents during a write cycle.
    assign rd_x = register[ra_x];
    assign rd_y = register[ra_y];
    assign rd_z = register[ra_z];

endmodule

// File: rtl/sp_core.sv
// SP datapath lane: register file, ALU with registered result and predicate, write-back mux.
// Define SPCORE_MAD_EN to enable multiply-add (aluc=4); otherwise that code yields 0.
module sp_core
    import sp_core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   x,
    input  logic [RA_W-1:0]   y,
    input  logic [RA_W-1:0]   z,
    input  logic [DATA_W-1:0] I,
    output logic              P,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              en,
    input  logic              reg_we,
    input  logic [3:0]        aluc,
    input  logic [1:0]        s2
);

    logic [DATA_W-1:0] rd_x, rd_y, rd_z;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] prod;
    logic              exec;

    assign exec = en && !reg_we;

    sp_regfile #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) RegFile (
        .clk   (clk),
        .reset (reset),
        .we    (en && reg_we),
        .wa    (x),
        .wd    (wb_data),
        .ra_x  (x),
        .ra_y  (y),
        .ra_z  (z),
        .rd_x  (rd_x),
        .rd_y  (rd_y),
        .rd_z  (rd_z)
    );

    assign data_out = rd_x;
    assign addr     = rd_y;

    // Products keep only the low DATA_W bits.
    assign prod = rd_y * rd_z;

    always_comb begin
        alu_res = '0;
        case (aluc)
            ALUC_ADD: alu_res = rd_y + rd_z;
            ALUC_SUB: alu_res = rd_y - rd_z;
            ALUC_MUL: alu_res = prod;
`ifdef SPCORE_MAD_EN
            ALUC_MAD: alu_res = rd_x + prod;
`endif
            ALUC_AND: alu_res = rd_y & rd_z;
            ALUC_OR:  alu_res = rd_y | rd_z;
            ALUC_XOR: alu_res = rd_y ^ rd_z;
            default:  alu_res = '0;
        endcase
    end

    // alu_q and P only move on execute cycles, so a held write-back rewrites the same value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q <= '0;
            P     <= 1'b0;
        end else if (exec) begin
            alu_q <= alu_res;
            if (aluc == ALUC_SLT) begin
                P <= (rd_y < rd_z);
            end else if (aluc == ALUC_SEQ) begin
                P <= (rd_y == rd_z);
            end else if (aluc == ALUC_CLEAR) begin
                P <= 1'b0;
            end
        end
    end

    always_comb begin
        wb_data = alu_q;
        case (s2)
            MUXD_FROM_ALU: wb_data = alu_q;
            MUXD_FROM_I:   wb_data = I;
            MUXD_FROM_MEM: wb_data = data_in;
            MUXD_FROM_REG: wb_data = rd_y;
            default:       wb_data = alu_q;
        endcase
    end

endmodule

// File: tb/tb_sp_core.sv
// Directed bench for sp_core: vector table of single-edge operations plus reset sequences.
// Expected register values for MAD follow the SPCORE_MAD_EN build option.
module tb_sp_core;
    import sp_core_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  x, y, z;
    logic [15:0] imm;
    logic        p;
    logic [15:0] data_out;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        en;
    logic        reg_we;
    logic [3:0]  aluc;
    logic [1:0]  s2;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] exp_q[$];

`ifdef SPCORE_MAD_EN
    localparam logic [15:0] MAD_V = 16'd251;
`else
    localparam logic [15:0] MAD_V = 16'd0;
`endif

    typedef struct {
        logic        en;
        logic        we;
        logic [3:0]  aluc;
        logic [1:0]  s2;
        logic [3:0]  x, y, z;
        logic [15:0] imm;
        logic [15:0] din;
        logic [3:0]  chk;
        logic [15:0] exp_r;
        logic        exp_p;
        logic [15:0] exp_addr;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    sp_core dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .z        (z),
        .I        (imm),
        .P        (p),
        .data_out (data_out),
        .addr     (addr),
        .data_in  (data_in),
        .en       (en),
        .reg_we   (reg_we),
        .aluc     (aluc),
        .s2       (s2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic w, input logic [3:0] op, input logic [1:0] src,
                                input logic [3:0] vx, input logic [3:0] vy, input logic [3:0] vz,
                                input logic [15:0] vi, input logic [15:0] vd, input logic [3:0] c,
                                input logic [15:0] er, input logic ep, input logic [15:0] ea,
                                input logic [15:0] eo);
        vec_t v;
        v.en = e; v.we = w; v.aluc = op; v.s2 = src;
        v.x = vx; v.y = vy; v.z = vz; v.imm = vi; v.din = vd;
        v.chk = c; v.exp_r = er; v.exp_p = ep; v.exp_addr = ea; v.exp_dout = eo;
        return v;
    endfunction

    // Driver: set inputs just after an edge, let one rising edge happen, sample 1 unit later.
    task automatic drive(input vec_t v);
        en = v.en; reg_we = v.we; aluc = v.aluc; s2 = v.s2;
        x = v.x; y = v.y; z = v.z; imm = v.imm; data_in = v.din;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; reg_we = 1'b0; aluc = ALUC_CLEAR; s2 = MUXD_FROM_ALU;
        x = 4'd0; y = 4'd0; z = 4'd0; imm = 16'd0; data_in = 16'd0;
    endtask

    initial begin
        logic [15:0] e;
        idle_inputs();
        reset = 1'b1;
        #(CLK_PERIOD * 2 + 3);

        // Reset state
        for (int i = 0; i < 16; i++) begin
            check($sformatf("reset_r%0d", i), dut.RegFile.register[i], 16'd0);
        end
        check("reset_p", {15'd0, p}, 16'd0);
        check("reset_addr", addr, 16'd0);
        check("reset_dout", data_out, 16'd0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        //           en we aluc        s2             x  y  z  imm      din       chk exp_r     p  addr      dout
        vecs.push_back(mk(0, 1, ALUC_CLEAR, MUXD_FROM_I,   0, 0, 1, 16'h1234, 16'h0, 0, 16'd0,    0, 16'd0,    16'd0));
        vecs.push_back(mk(1, 1, ALUC_CLEAR, MUXD_FROM_I,   0, 0, 1, 16'd11,   16'h0, 0, 16'd11,   0, 16'd11,   16'd11));
        vecs.push_back(mk(1, 1, ALUC_CLEAR, MUXD_FROM_I,   1, 0, 1, 16'd20,   16'h0, 1, 16'd20,   0, 16'd11,   16'd20));
        vecs.push_back(mk(1, 0, ALUC_ADD,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd0,    0, 16'd11,   16'd0));
        vecs.push_back(mk(1, 1, ALUC_ADD,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd31,   0, 16'd11,   16'd31));
        vecs.push_back(mk(1, 0, ALUC_MAD,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd31,   0, 16'd11,   16'd31));
        vecs.push_back(mk(1, 1, ALUC_MAD,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, MAD_V,    0, 16'd11,   MAD_V));
        vecs.push_back(mk(1, 1, ALUC_MAD,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, MAD_V,    0, 16'd11,   MAD_V));
        vecs.push_back(mk(1, 0, ALUC_ADD,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, MAD_V,    0, 16'd11,   MAD_V));
        vecs.push_back(mk(1, 1, ALUC_ADD,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd31,   0, 16'd11,   16'd31));
        vecs.push_back(mk(1, 0, ALUC_MUL,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd31,   0, 16'd11,   16'd31));
        vecs.push_back(mk(1, 1, ALUC_MUL,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd220,  0, 16'd11,   16'd220));
        vecs.push_back(mk(1, 1, ALUC_CLEAR, MUXD_FROM_I,   3, 0, 1, 16'd300,  16'h0, 3, 16'd300,  0, 16'd11,   16'd300));
        vecs.push_back(mk(1, 0, ALUC_MUL,   MUXD_FROM_ALU, 4, 3, 3, 16'd0,    16'h0, 4, 16'd0,    0, 16'd300,  16'd0));
        vecs.push_back(mk(1, 1, ALUC_MUL,   MUXD_FROM_ALU, 4, 3, 3, 16'd0,    16'h0, 4, 16'h5F90, 0, 16'd300,  16'h5F90));
        vecs.push_back(mk(1, 0, ALUC_SLT,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd220,  1, 16'd11,   16'd220));
        vecs.push_back(mk(1, 0, ALUC_SEQ,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd220,  0, 16'd11,   16'd220));
        vecs.push_back(mk(1, 0, ALUC_SEQ,   MUXD_FROM_ALU, 2, 3, 3, 16'd0,    16'h0, 2, 16'd220,  1, 16'd300,  16'd220));
        vecs.push_back(mk(1, 0, ALUC_ADD,   MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd220,  1, 16'd11,   16'd220));
        vecs.push_back(mk(1, 0, ALUC_CLEAR, MUXD_FROM_ALU, 2, 0, 1, 16'd0,    16'h0, 2, 16'd220,  0, 16'd11,   16'd220));
        vecs.push_back(mk(1, 1, ALUC_CLEAR, MUXD_FROM_MEM, 5, 0, 1, 16'd0,    16'hBEEF, 5, 16'hBEEF, 0, 16'd11, 16'hBEEF));
        vecs.push_back(mk(1, 1, ALUC_CLEAR, MUXD_FROM_REG, 6, 5, 1, 16'd0,    16'h0, 6, 16'hBEEF, 0, 16'hBEEF, 16'hBEEF));
        vecs.push_back(mk(0, 0, ALUC_SLT,   MUXD_FROM_ALU, 6, 0, 1, 16'd0,    16'h0, 6, 16'hBEEF, 0, 16'd11,   16'hBEEF));
        vecs.push_back(mk(0, 1, ALUC_CLEAR, MUXD_FROM_I,   6, 0, 1, 16'd1,    16'h0, 6, 16'hBEEF, 0, 16'd11,   16'hBEEF));
        vecs.push_back(mk(1, 0, ALUC_SUB,   MUXD_FROM_ALU, 7, 0, 1, 16'd0,    16'h0, 7, 16'd0,    0, 16'd11,   16'd0));
        vecs.push_back(mk(1, 1, ALUC_SUB,   MUXD_FROM_ALU, 7, 0, 1, 16'd0,    16'h0, 7, 16'hFFF7, 0, 16'd11,   16'hFFF7));
        vecs.push_back(mk(1, 0, ALUC_AND,   MUXD_FROM_ALU, 8, 5, 4, 16'd0,    16'h0, 8, 16'd0,    0, 16'hBEEF, 16'd0));
        vecs.push_back(mk(1, 1, ALUC_AND,   MUXD_FROM_ALU, 8, 5, 4, 16'd0,    16'h0, 8, 16'h1E80, 0, 16'hBEEF, 16'h1E80));
        vecs.push_back(mk(1, 0, ALUC_XOR,   MUXD_FROM_ALU, 9, 5, 4, 16'd0,    16'h0, 9, 16'd0,    0, 16'hBEEF, 16'd0));
        vecs.push_back(mk(1, 1, ALUC_XOR,   MUXD_FROM_ALU, 9, 5, 4, 16'd0,    16'h0, 9, 16'hE17F, 0, 16'hBEEF, 16'hE17F));
        vecs.push_back(mk(1, 0, ALUC_OR,    MUXD_FROM_ALU, 10, 5, 4, 16'd0,   16'h0, 10, 16'd0,   0, 16'hBEEF, 16'd0));
        vecs.push_back(mk(1, 1, ALUC_OR,    MUXD_FROM_ALU, 10, 5, 4, 16'd0,   16'h0, 10, 16'hFFFF, 0, 16'hBEEF, 16'hFFFF));
        vecs.push_back(mk(1, 0, 4'd12,      MUXD_FROM_ALU, 11, 5, 4, 16'd0,   16'h0, 11, 16'd0,   0, 16'hBEEF, 16'd0));
        vecs.push_back(mk(1, 1, 4'd12,      MUXD_FROM_ALU, 11, 5, 4, 16'd0,   16'h0, 11, 16'd0,   0, 16'hBEEF, 16'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back(vecs[i].exp_r);
            exp_q.push_back({15'd0, vecs[i].exp_p});
            exp_q.push_back(vecs[i].exp_addr);
            exp_q.push_back(vecs[i].exp_dout);
            drive(vecs[i]);
            e = exp_q.pop_front();
            check($sformatf("v%0d_r%0d", i, vecs[i].chk), dut.RegFile.register[vecs[i].chk], e);
            e = exp_q.pop_front();
            check($sformatf("v%0d_p", i), {15'd0, p}, e);
            e = exp_q.pop_front();
            check($sformatf("v%0d_addr", i), addr, e);
            e = exp_q.pop_front();
            check($sformatf("v%0d_dout", i), data_out, e);
        end

        // Reset mid-operation: pending ADD result must not land after reset.
        drive(mk(1, 0, ALUC_ADD, MUXD_FROM_ALU, 2, 0, 1, 16'd0, 16'h0, 2, 16'd0, 0, 16'd0, 16'd0));
        drive(mk(1, 0, ALUC_SLT, MUXD_FROM_ALU, 2, 0, 1, 16'd0, 16'h0, 2, 16'd0, 0, 16'd0, 16'd0));
        check("pre_reset_p", {15'd0, p}, 16'd1);
        en = 1'b1; reg_we = 1'b1; s2 = MUXD_FROM_ALU; x = 4'd2;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_r2", dut.RegFile.register[2], 16'd0);
        check("async_reset_r5", dut.RegFile.register[5], 16'd0);
        check("async_reset_p", {15'd0, p}, 16'd0);
        check("async_reset_addr", addr, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_wb_r2", dut.RegFile.register[2], 16'd0);
        check("post_reset_dout", data_out, 16'd0);

        // R0 is general purpose and the first write after reset lands in one edge.
        drive(mk(1, 1, ALUC_CLEAR, MUXD_FROM_I, 0, 0, 0, 16'hA5A5, 16'h0, 0, 16'd0, 0, 16'd0, 16'd0));
        check("r0_write", dut.RegFile.register[0], 16'hA5A5);
        check("r0_addr", addr, 16'hA5A5);

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
